// File: rtl/disp_pkg.sv
// Shared encodings and defaults for the display/draw VRAM read arbiter.
package disp_pkg;

  // One-hot FSM encoding: a single burst in flight at any time.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ADDR = 3'b010,
    S_DATA = 3'b100
  } state_t;

  // One-hot ownership codes driven on GRANT.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Consecutive M0 grants tolerated while M1 waits.
  localparam int STARVE_MAX_DEF = 4;

  // Starvation counter width; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/disp_arbpri.sv
// Combinational winner pick: M0 over M1, unless M1 has waited out its budget.
module disp_arbpri
  import disp_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CW         = cnt_width(STARVE_MAX)
) (
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic [CW-1:0] starve_cnt,
  output logic [1:0]    pick,
  output logic          forced
);

  logic at_limit;

  assign at_limit = (starve_cnt == CW'(STARVE_MAX));

  // Priority select; forced marks an M1 win that overrode a pending M0.
  always_comb begin
    pick   = GRANT_NONE;
    forced = 1'b0;
    if (m1_req && at_limit) begin
      pick   = GRANT_M1;
      forced = m0_req;
    end else if (m0_req) begin
      pick = GRANT_M0;
    end else if (m1_req) begin
      pick = GRANT_M1;
    end
  end

endmodule

// File: rtl/disp_axiarb.sv
// Two-requester AXI read-channel arbiter in front of the VRAM slave.
module disp_axiarb
  import disp_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        ACLK,
  input  logic        ARSTN,
  input  logic [31:0] M0_ARADDR,
  input  logic        M0_ARVALID,
  output logic        M0_ARREADY,
  output logic [31:0] M0_RDATA,
  output logic        M0_RLAST,
  output logic        M0_RVALID,
  input  logic        M0_RREADY,
  input  logic [31:0] M1_ARADDR,
  input  logic        M1_ARVALID,
  output logic        M1_ARREADY,
  output logic [31:0] M1_RDATA,
  output logic        M1_RLAST,
  output logic        M1_RVALID,
  input  logic        M1_RREADY,
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [1:0]  GRANT,
  output logic        STARVED
);

  localparam int CW = cnt_width(STARVE_MAX);

  state_t        state_reg, state_next;
  logic [1:0]    grant_reg, grant_next;
  logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
  logic          starved_reg, starved_next;
  logic          run_reg;
  logic [1:0]    pick;
  logic          forced;
  logic          in_addr, in_data;

  disp_arbpri #(
    .STARVE_MAX(STARVE_MAX),
    .CW        (CW)
  ) u_arbpri (
    .m0_req    (M0_ARVALID),
    .m1_req    (M1_ARVALID),
    .starve_cnt(starve_cnt_reg),
    .pick      (pick),
    .forced    (forced)
  );

  assign in_addr = (state_reg == S_ADDR);
  assign in_data = (state_reg == S_DATA);

  // Address channel: only the owner reaches the slave, only in S_ADDR.
  assign ARADDR     = grant_reg[0] ? M0_ARADDR : (grant_reg[1] ? M1_ARADDR : 32'h0);
  assign ARVALID    = in_addr & ((grant_reg[0] & M0_ARVALID) | (grant_reg[1] & M1_ARVALID));
  assign M0_ARREADY = in_addr & grant_reg[0] & ARREADY;
  assign M1_ARREADY = in_addr & grant_reg[1] & ARREADY;

  // Read channel: data fans out to both, handshake signals to the owner only.
  assign M0_RDATA  = RDATA;
  assign M1_RDATA  = RDATA;
  assign M0_RVALID = in_data & grant_reg[0] & RVALID;
  assign M1_RVALID = in_data & grant_reg[1] & RVALID;
  assign M0_RLAST  = in_data & grant_reg[0] & RLAST;
  assign M1_RLAST  = in_data & grant_reg[1] & RLAST;
  assign RREADY    = in_data & ((grant_reg[0] & M0_RREADY) | (grant_reg[1] & M1_RREADY));

  assign GRANT   = grant_reg;
  assign STARVED = starved_reg;

  // Hold off arbitration for one edge after reset release.
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) run_reg <= 1'b0;
    else        run_reg <= 1'b1;
  end

  // FSM, ownership, starvation counter and pulse registers.
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state_reg      <= S_IDLE;
      grant_reg      <= GRANT_NONE;
      starve_cnt_reg <= '0;
      starved_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      starve_cnt_reg <= starve_cnt_next;
      starved_reg    <= starved_next;
    end
  end

  // Next-state: grant on request, advance on AR handshake, release on last beat.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    starve_cnt_next = starve_cnt_reg;
    starved_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (run_reg && (M0_ARVALID || M1_ARVALID)) begin
          state_next   = S_ADDR;
          grant_next   = pick;
          starved_next = forced;
          if (pick == GRANT_M1)
            starve_cnt_next = '0;
          else if (M1_ARVALID && (starve_cnt_reg != CW'(STARVE_MAX)))
            starve_cnt_next = starve_cnt_reg + CW'(1);
        end
      end
      S_ADDR: begin
        if (ARVALID && ARREADY)
          state_next = S_DATA;
      end
      S_DATA: begin
        if (RVALID && RREADY && RLAST) begin
          state_next = S_IDLE;
          grant_next = GRANT_NONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        grant_next = GRANT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_disp_axiarb.sv
// Directed bench for disp_axiarb with hand-computed expectations.
module tb_disp_axiarb;

  logic        ACLK = 1'b0;
  logic        ARSTN;
  logic [31:0] M0_ARADDR, M1_ARADDR;
  logic        M0_ARVALID, M1_ARVALID;
  logic        M0_ARREADY, M1_ARREADY;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic        M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID;
  logic        M0_RREADY, M1_RREADY;
  logic [31:0] ARADDR;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic        RLAST, RVALID, RREADY;
  logic [1:0]  GRANT;
  logic        STARVED;

  int checks = 0;
  int errors = 0;

  int exp_grant   [6] = '{1, 1, 1, 1, 2, 1};
  int exp_starved [6] = '{0, 0, 0, 0, 1, 0};

  always #5 ACLK = ~ACLK;

  disp_axiarb #(.STARVE_MAX(4)) dut (
    .ACLK(ACLK), .ARSTN(ARSTN),
    .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RDATA(M1_RDATA), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .GRANT(GRANT), .STARVED(STARVED)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ARSTN = 1'b0;
    M0_ARADDR = '0; M1_ARADDR = '0; M0_ARVALID = 0; M1_ARVALID = 0;
    M0_RREADY = 1; M1_RREADY = 1;
    ARREADY = 0; RDATA = '0; RLAST = 0; RVALID = 0;

    // Reset state
    cyc(); cyc(); settle();
    chk("rst_grant", 32'(GRANT), 0);
    chk("rst_arvalid", 32'(ARVALID), 0);
    chk("rst_rready", 32'(RREADY), 0);
    chk("rst_starved", 32'(STARVED), 0);
    chk("rst_m0_arready", 32'(M0_ARREADY), 0);

    // Single M0 burst, 8 beats; first grant on second edge after release
    ARSTN = 1'b1; M0_ARVALID = 1; M0_ARADDR = 32'h1000;
    cyc(); settle();
    chk("s1_first_edge_grant", 32'(GRANT), 0);
    cyc(); settle();
    chk("s1_grant", 32'(GRANT), 1);
    chk("s1_araddr", ARADDR, 32'h1000);
    chk("s1_arvalid", 32'(ARVALID), 1);
    chk("s1_m0_arready_wait", 32'(M0_ARREADY), 0);
    cyc();
    ARREADY = 1; settle();
    chk("s1_m0_arready", 32'(M0_ARREADY), 1);
    chk("s1_m1_arready", 32'(M1_ARREADY), 0);
    cyc();
    ARREADY = 0; M0_ARVALID = 0; settle();
    chk("s1_data_arvalid", 32'(ARVALID), 0);
    for (int i = 0; i < 8; i++) begin
      RVALID = 1; RDATA = 32'hD000_0000 + 32'(i); RLAST = (i == 7);
      settle();
      chk("s1_m0_rvalid", 32'(M0_RVALID), 1);
      chk("s1_m0_rdata", M0_RDATA, 32'hD000_0000 + 32'(i));
      chk("s1_m0_rlast", 32'(M0_RLAST), (i == 7) ? 1 : 0);
      chk("s1_m1_rvalid", 32'(M1_RVALID), 0);
      chk("s1_rready", 32'(RREADY), 1);
      cyc();
    end
    RVALID = 0; RLAST = 0; settle();
    chk("s1_idle_grant", 32'(GRANT), 0);
    $display("burst M0 addr 0x1000 beats 8 done");

    // M0 drops ARVALID in S_ADDR; grant is kept
    M0_ARVALID = 1; M0_ARADDR = 32'h4000;
    cyc();
    M0_ARVALID = 0; settle();
    chk("s2_arvalid_dropped", 32'(ARVALID), 0);
    chk("s2_grant_held", 32'(GRANT), 1);
    cyc();
    ARREADY = 1; settle();
    cyc(); settle();
    chk("s2_grant_no_hs", 32'(GRANT), 1);
    chk("s2_still_addr_rready", 32'(RREADY), 0);
    M0_ARVALID = 1; settle();
    chk("s2_arvalid_back", 32'(ARVALID), 1);
    cyc();
    ARREADY = 0; M0_ARVALID = 0; RVALID = 1; RLAST = 1; settle();
    chk("s2_m0_rvalid", 32'(M0_RVALID), 1);
    cyc();
    RVALID = 0; RLAST = 0; settle();
    chk("s2_idle_grant", 32'(GRANT), 0);
    $display("burst M0 addr 0x4000 beats 1 done");

    // M1 burst with M1_RREADY stall, plus a stray RLAST without RVALID
    M1_ARVALID = 1; M1_ARADDR = 32'h5000;
    cyc(); settle();
    chk("s3_grant", 32'(GRANT), 2);
    chk("s3_araddr", ARADDR, 32'h5000);
    ARREADY = 1; settle();
    chk("s3_m1_arready", 32'(M1_ARREADY), 1);
    chk("s3_m0_arready", 32'(M0_ARREADY), 0);
    cyc();
    ARREADY = 0; M1_ARVALID = 0; RVALID = 0; RLAST = 1;
    cyc(); settle();
    chk("s3_rlast_no_rvalid", 32'(GRANT), 2);
    M1_RREADY = 0; RVALID = 1; RLAST = 0; RDATA = 32'hAAAA_0001; settle();
    chk("s3_rready_stall", 32'(RREADY), 0);
    chk("s3_m1_rvalid", 32'(M1_RVALID), 1);
    cyc(); settle();
    chk("s3_stall_grant", 32'(GRANT), 2);
    chk("s3_stall_rdata", M1_RDATA, 32'hAAAA_0001);
    M1_RREADY = 1; settle();
    chk("s3_rready", 32'(RREADY), 1);
    cyc();
    RDATA = 32'hAAAA_0002; RLAST = 1; settle();
    chk("s3_m1_rlast", 32'(M1_RLAST), 1);
    chk("s3_m0_rlast", 32'(M0_RLAST), 0);
    chk("s3_m0_rvalid", 32'(M0_RVALID), 0);
    chk("s3_m1_rdata2", M1_RDATA, 32'hAAAA_0002);
    cyc();
    RVALID = 0; RLAST = 0; settle();
    chk("s3_idle_grant", 32'(GRANT), 0);
    $display("burst M1 addr 0x5000 beats 2 done");

    // Both pending continuously: M0 x4, forced M1, then M0
    M0_ARVALID = 1; M0_ARADDR = 32'h0000_A000;
    M1_ARVALID = 1; M1_ARADDR = 32'h0000_B000;
    for (int k = 0; k < 6; k++) begin
      cyc(); settle();
      chk("s4_grant", 32'(GRANT), 32'(exp_grant[k]));
      chk("s4_starved", 32'(STARVED), 32'(exp_starved[k]));
      chk("s4_araddr", ARADDR, (exp_grant[k] == 1) ? 32'h0000_A000 : 32'h0000_B000);
      ARREADY = 1;
      cyc();
      ARREADY = 0; RVALID = 1; RLAST = 1; RDATA = 32'(k);
      if (k == 5) begin
        M0_ARVALID = 0; M1_ARVALID = 0;
      end
      settle();
      chk("s4_starved_clear", 32'(STARVED), 0);
      chk("s4_arvalid_in_data", 32'(ARVALID), 0);
      cyc();
      RVALID = 0; RLAST = 0; settle();
      chk("s4_idle_grant", 32'(GRANT), 0);
      chk("s4_idle_arvalid", 32'(ARVALID), 0);
      $display("burst %0d owner %0d done", k, exp_grant[k]);
    end

    // Last beat coincides with a new M1 request: one idle cycle between
    M0_ARVALID = 1; M0_ARADDR = 32'h3000;
    cyc(); settle();
    chk("s5_grant_m0", 32'(GRANT), 1);
    ARREADY = 1;
    cyc();
    ARREADY = 0; M0_ARVALID = 0; RVALID = 1; RLAST = 0;
    cyc();
    RLAST = 1; M1_ARVALID = 1; M1_ARADDR = 32'h2222_0000; settle();
    chk("s5_no_overlap", 32'(ARVALID), 0);
    chk("s5_m0_rlast", 32'(M0_RLAST), 1);
    cyc();
    RVALID = 0; RLAST = 0; settle();
    chk("s5_idle_grant", 32'(GRANT), 0);
    chk("s5_idle_arvalid", 32'(ARVALID), 0);
    cyc(); settle();
    chk("s5_grant_m1", 32'(GRANT), 2);
    chk("s5_arvalid", 32'(ARVALID), 1);
    chk("s5_araddr", ARADDR, 32'h2222_0000);
    chk("s5_m1_rvalid", 32'(M1_RVALID), 0);
    ARREADY = 1;
    cyc();
    ARREADY = 0; M1_ARVALID = 0; RVALID = 1; RLAST = 1;
    cyc();
    RVALID = 0; RLAST = 0; settle();
    chk("s5_end_grant", 32'(GRANT), 0);
    $display("burst M0 addr 0x3000 then M1 addr 0x22220000 done");

    // Reset at beat 3 of an M0 burst, then a normal M1 grant
    M0_ARVALID = 1; M0_ARADDR = 32'h6000;
    cyc();
    ARREADY = 1;
    cyc();
    ARREADY = 0; M0_ARVALID = 0;
    for (int i = 0; i < 3; i++) begin
      RVALID = 1; RLAST = 0;
      cyc();
    end
    RVALID = 1; RLAST = 1; settle();
    chk("s6_pre_rst_rvalid", 32'(M0_RVALID), 1);
    ARSTN = 0; settle();
    chk("s6_rst_grant", 32'(GRANT), 0);
    chk("s6_rst_m0_rvalid", 32'(M0_RVALID), 0);
    chk("s6_rst_m0_rlast", 32'(M0_RLAST), 0);
    chk("s6_rst_rready", 32'(RREADY), 0);
    chk("s6_rst_arvalid", 32'(ARVALID), 0);
    cyc();
    RVALID = 0; RLAST = 0;
    ARSTN = 1; M1_ARVALID = 1; M1_ARADDR = 32'h7000;
    cyc(); settle();
    chk("s6_first_edge_grant", 32'(GRANT), 0);
    cyc(); settle();
    chk("s6_grant_m1", 32'(GRANT), 2);
    chk("s6_araddr", ARADDR, 32'h7000);
    chk("s6_starved", 32'(STARVED), 0);
    ARREADY = 1;
    cyc();
    ARREADY = 0; M1_ARVALID = 0; RVALID = 1; RLAST = 1; settle();
    chk("s6_m1_rvalid", 32'(M1_RVALID), 1);
    cyc();
    RVALID = 0; RLAST = 0; settle();
    chk("s6_end_grant", 32'(GRANT), 0);
    $display("burst M1 addr 0x7000 after reset done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
